// File: rtl/swap_engine.sv
// Operand swap engine: exchanges two WIDTH-bit operands using one of four methods
// (temp register, add/sub, xor, concat). Define SWAP_ERR_CHECK_EN to build in the result checker.
module swap_engine #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [1:0]       out_mode,
  output logic [15:0]      swap_cnt,
  output logic             err
);

  typedef enum logic [2:0] {IDLE, S1, S2, S3, DONE} state_t;

  localparam logic [1:0] MODE_TEMP   = 2'd0;
  localparam logic [1:0] MODE_ADDSUB = 2'd1;
  localparam logic [1:0] MODE_XOR    = 2'd2;
  localparam logic [1:0] MODE_CAT    = 2'd3;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_t;
  logic [1:0]       r_mode;
  logic [15:0]      r_cnt;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [WIDTH-1:0] w_t_nxt;
  logic             w_accept;
  logic             w_out_hs;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_out_hs = out_ready && (r_state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = S1;
      S1:      w_state_nxt = (r_mode == MODE_CAT) ? DONE : S2;
      S2:      w_state_nxt = S3;
      S3:      w_state_nxt = DONE;
      DONE:    if (w_out_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // One swap micro-step per state; the three-step methods never see mode 3 past S1.
  always_comb begin
    w_a_nxt = r_a;
    w_b_nxt = r_b;
    w_t_nxt = r_t;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_a_nxt = in_a;
          w_b_nxt = in_b;
        end
      end
      S1: begin
        case (r_mode)
          MODE_TEMP:   w_t_nxt = r_a;
          MODE_ADDSUB: w_a_nxt = r_a + r_b;
          MODE_XOR:    w_a_nxt = r_a ^ r_b;
          MODE_CAT: begin
            w_a_nxt = r_b;
            w_b_nxt = r_a;
          end
          default: ;
        endcase
      end
      S2: begin
        case (r_mode)
          MODE_TEMP:   w_a_nxt = r_b;
          MODE_ADDSUB: w_b_nxt = r_a - r_b;
          MODE_XOR:    w_b_nxt = r_a ^ r_b;
          default: ;
        endcase
      end
      S3: begin
        case (r_mode)
          MODE_TEMP:   w_b_nxt = r_t;
          MODE_ADDSUB: w_a_nxt = r_a - r_b;
          MODE_XOR:    w_a_nxt = r_a ^ r_b;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_t    <= '0;
      r_mode <= '0;
      r_cnt  <= '0;
    end else begin
      r_a <= w_a_nxt;
      r_b <= w_b_nxt;
      r_t <= w_t_nxt;
      if (w_accept) r_mode <= in_mode;
      if (w_out_hs) r_cnt  <= sat_inc(r_cnt);
    end
  end

  assign out_a    = r_a;
  assign out_b    = r_b;
  assign out_mode = r_mode;
  assign swap_cnt = r_cnt;

`ifdef SWAP_ERR_CHECK_EN
  logic [WIDTH-1:0] r_orig_a;
  logic [WIDTH-1:0] r_orig_b;
  logic             r_err;

  // Verdict is taken from the values being written on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_orig_a <= '0;
      r_orig_b <= '0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_orig_a <= in_a;
      r_orig_b <= in_b;
      r_err    <= 1'b0;
    end else if ((w_state_nxt == DONE) && (r_state != DONE)) begin
      r_err <= (w_a_nxt != r_orig_b) || (w_b_nxt != r_orig_a);
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_swap_engine.sv
// Self-checking bench for swap_engine: vector table, random swaps, backpressure and reset abort.
module tb_swap_engine;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [1:0]   in_mode = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_a;
  logic [W-1:0] out_b;
  logic [1:0]   out_mode;
  logic [15:0]  swap_cnt;
  logic         err;

  always #5 clk = ~clk;

  swap_engine #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_mode(out_mode),
    .swap_cnt(swap_cnt), .err(err)
  );

  typedef struct packed {
    logic [1:0]   mode;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
  } sb_t;

  typedef struct packed {
    logic [1:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic [3:0]   lat;
  } vec_t;

  sb_t         sb_q[$];
  vec_t        vecs[13];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one request once the engine is idle; the expected result goes on the scoreboard.
  task automatic issue(input logic [1:0] m, input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input logic [W-1:0] xea, input logic [W-1:0] xeb);
    int guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("in_ready_before_issue", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_mode  = m;
    in_a     = xa;
    in_b     = xb;
    sb_q.push_back('{mode: m, ea: xea, eb: xeb});
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    in_mode  = 2'($urandom);
  endtask

  // Wait for the result, compare against the scoreboard, optionally complete the handshake.
  task automatic collect(input int exp_lat, input logic do_hs);
    int  lat = 0;
    sb_t e;
    while (!out_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue, expected a pending result");
    end else begin
      e = sb_q.pop_front();
      chk("out_a", 64'(out_a), 64'(e.ea));
      chk("out_b", 64'(out_b), 64'(e.eb));
      chk("out_mode", 64'(out_mode), 64'(e.mode));
      chk("err_done", 64'(err), 64'd0);
    end
    if (do_hs) begin
      @(posedge clk); #1;
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      chk("out_valid_after_hs", 64'(out_valid), 64'd0);
      chk("swap_cnt", 64'(swap_cnt), 64'(exp_cnt));
    end
  endtask

  initial begin
    vecs[0]  = '{mode: 2'd0, a: 32'd254,        b: 32'd566,        ea: 32'd566,        eb: 32'd254,        lat: 4'd3};
    vecs[1]  = '{mode: 2'd0, a: 32'd0,          b: 32'hFFFF_FFFF,  ea: 32'hFFFF_FFFF,  eb: 32'd0,          lat: 4'd3};
    vecs[2]  = '{mode: 2'd0, a: 32'd7,          b: 32'd7,          ea: 32'd7,          eb: 32'd7,          lat: 4'd3};
    vecs[3]  = '{mode: 2'd1, a: 32'd100,        b: 32'd426,        ea: 32'd426,        eb: 32'd100,        lat: 4'd3};
    vecs[4]  = '{mode: 2'd1, a: 32'hFFFF_FFFF,  b: 32'd2,          ea: 32'd2,          eb: 32'hFFFF_FFFF,  lat: 4'd3};
    vecs[5]  = '{mode: 2'd1, a: 32'd0,          b: 32'hFFFF_FFFF,  ea: 32'hFFFF_FFFF,  eb: 32'd0,          lat: 4'd3};
    vecs[6]  = '{mode: 2'd1, a: 32'd9,          b: 32'd9,          ea: 32'd9,          eb: 32'd9,          lat: 4'd3};
    vecs[7]  = '{mode: 2'd2, a: 32'd799,        b: 32'd826,        ea: 32'd826,        eb: 32'd799,        lat: 4'd3};
    vecs[8]  = '{mode: 2'd2, a: 32'd5,          b: 32'd5,          ea: 32'd5,          eb: 32'd5,          lat: 4'd3};
    vecs[9]  = '{mode: 2'd2, a: 32'hFFFF_FFFF,  b: 32'd0,          ea: 32'd0,          eb: 32'hFFFF_FFFF,  lat: 4'd3};
    vecs[10] = '{mode: 2'd3, a: 32'd110,        b: 32'd221,        ea: 32'd221,        eb: 32'd110,        lat: 4'd1};
    vecs[11] = '{mode: 2'd3, a: 32'd0,          b: 32'hFFFF_FFFF,  ea: 32'hFFFF_FFFF,  eb: 32'd0,          lat: 4'd1};
    vecs[12] = '{mode: 2'd3, a: 32'd3,          b: 32'd3,          ea: 32'd3,          eb: 32'd3,          lat: 4'd1};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_swap_cnt", 64'(swap_cnt), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_out_mode", 64'(out_mode), 64'd0);
    chk("rst_out_a", 64'(out_a), 64'd0);
    chk("rst_out_b", 64'(out_b), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].ea, vecs[i].eb);
      collect(int'(vecs[i].lat), 1'b1);
    end

    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [1:0]   rm;
      ra = $urandom;
      rb = $urandom;
      rm = 2'(i);
      issue(rm, ra, rb, rb, ra);
      collect((rm == 2'd3) ? 1 : 3, 1'b1);
    end

    // Backpressure: result must hold, new request must wait until a cycle after the handshake
    out_ready = 1'b0;
    issue(2'd0, 32'd11, 32'd22, 32'd22, 32'd11);
    collect(3, 1'b0);
    in_valid = 1'b1;
    in_mode  = 2'd1;
    in_a     = 32'd33;
    in_b     = 32'd44;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_a", 64'(out_a), 64'd22);
      chk("bp_out_b", 64'(out_b), 64'd11);
      chk("bp_out_mode", 64'(out_mode), 64'd0);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_swap_cnt", 64'(swap_cnt), 64'(exp_cnt));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 16'd1;
    chk("bp_hs_out_valid", 64'(out_valid), 64'd0);
    chk("bp_hs_in_ready", 64'(in_ready), 64'd1);
    chk("bp_hs_swap_cnt", 64'(swap_cnt), 64'(exp_cnt));
    sb_q.push_back('{mode: 2'd1, ea: 32'd44, eb: 32'd33});
    @(posedge clk); #1;
    chk("bp_accept_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    collect(3, 1'b1);

    // Reset while in S2 of an add/sub swap
    issue(2'd1, 32'd545, 32'd369, 32'd369, 32'd545);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_q.delete();
    exp_cnt = '0;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_swap_cnt", 64'(swap_cnt), 64'd0);
    chk("abort_err", 64'(err), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("abort_no_response", 64'(out_valid), 64'd0);
    end

    issue(2'd3, 32'd110, 32'd221, 32'd221, 32'd110);
    collect(1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/swap_engine.md
SWAP_ENGINE -- requirements
Module: swap_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of each operand.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports in_valid input 1 and in_ready output 1; request handshake.
REQ-005 SHALL have ports in_a, in_b  input  WIDTH  operands to swap.
REQ-006 SHALL have port in_mode  input  2  swap method: 0 temp, 1 add/sub, 2 xor, 3 concat.
REQ-007 SHALL have ports out_valid output 1 and out_ready input 1; response handshake.
REQ-008 SHALL have ports out_a, out_b  output  WIDTH  swapped result.
REQ-009 SHALL have port out_mode  output  2  mode of the current result.
REQ-010 SHALL have port swap_cnt  output  16  completed-response count.
REQ-011 SHALL have port err  output  1  result-mismatch flag, per Configuration.

Function
REQ-012 SHALL implement FSM states IDLE, S1, S2, S3, DONE; in_ready=1 only in IDLE.
REQ-013 SHALL accept on rising edge with in_valid&&in_ready: capture in_a/in_b into A/B working regs, in_mode, and originals; go to S1.
REQ-014 SHALL, mode 0: S1 edge T=A->S2; S2 edge A=B->S3; S3 edge B=T->DONE.
REQ-015 SHALL, mode 1: S1 edge A=A+B; S2 edge B=A-B; S3 edge A=A-B; all modulo 2^WIDTH, carries discarded.
REQ-016 SHALL, mode 2: S1 edge A=A^B; S2 edge B=A^B; S3 edge A=A^B.
REQ-017 SHALL, mode 3: S1 edge {A,B}={B,A} in one step, S1->DONE directly.
REQ-018 SHALL give latency from accept edge to out_valid high: 3 cycles modes 0-2, 1 cycle mode 3.
REQ-019 SHALL hold out_valid=1 and out_a/out_b/out_mode stable in DONE until out_valid&&out_ready on an edge, then go to IDLE.
REQ-020 SHALL drive out_a=A, out_b=B from working regs; values outside DONE are don't-care for checking.
REQ-021 SHALL not accept a new request in the DONE handshake cycle; next accept earliest one cycle later in IDLE.
REQ-022 SHALL ignore in_* changes while not in IDLE.
REQ-023 SHALL increment swap_cnt on each out handshake, saturating at 16'hFFFF.
REQ-024 SHALL swap correctly for a==b and for operands 0 and all-ones in every mode.

Reset
REQ-025 SHALL, with rst_n=0 at a rising edge, go to IDLE; clear A, B, T, originals, out_mode, swap_cnt, err; out_valid=0; in_ready=1 from the next cycle.
REQ-026 SHALL abort any in-flight swap on reset in any state with no response issued and swap_cnt unchanged.

Configuration
REQ-027 SHALL use macro SWAP_ERR_CHECK_EN to compile in the result checker.
REQ-028 SHALL, with SWAP_ERR_CHECK_EN defined, on entry to DONE set err=1 if out_a!=orig_b or out_b!=orig_a, else 0; err held until next accept or reset.
REQ-029 SHALL, without SWAP_ERR_CHECK_EN, keep port err, tied constant 0, and omit the originals registers.

Verification
REQ-030 SHALL check: mode 0, a=254, b=566, out_ready=1 -> out_valid 3 cycles after accept, out_a=566, out_b=254, swap_cnt=1.
REQ-031 SHALL check: mode 1, a=100, b=426; then a=32'hFFFFFFFF, b=2 -> 426/100, then 2/32'hFFFFFFFF, no overflow error.
REQ-032 SHALL check: mode 2, a=799, b=826 and a=b=5 -> 826/799 and 5/5; mode 3, a=110, b=221 -> 221/110 after 1 cycle.
REQ-033 SHALL check: out_ready low 5 cycles in DONE, in_valid high with new data -> outputs stable, in_ready=0, no accept until 1 cycle after handshake.
REQ-034 SHALL check: rst_n low in S2 of mode 1, a=545, b=369 -> IDLE next cycle, out_valid=0, swap_cnt=0, err=0.
REQ-035 SHALL check, with SWAP_ERR_CHECK_EN: all modes with random operands -> err=0 in every DONE; without macro -> err constant 0.
